// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory fetch block.
package imem_pkg;

    // Fault code attached to every fetch response.
    typedef enum logic [1:0] {
        FLT_NONE     = 2'd0,
        FLT_MISALIGN = 2'd1,
        FLT_RANGE    = 2'd2
    } fault_e;

    // addi x0, x0, 0 -- returned whenever a fetch faults.
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Misalignment outranks an out-of-range word index.
    function automatic fault_e classify_fault(input logic misaligned, input logic out_of_range);
        if (misaligned) begin
            return FLT_MISALIGN;
        end
        if (out_of_range) begin
            return FLT_RANGE;
        end
        return FLT_NONE;
    endfunction

endpackage

// File: rtl/instr_mem_fetch_if.sv
// Fetch request/response channel between the fetch stage (master) and the
// instruction memory (slave), including the redirect flush.
interface instr_mem_fetch_if #(
    parameter int XLEN = 32,
    parameter int AW   = 32
);
    import imem_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   req_addr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_instr;
    fault_e          rsp_fault;
    logic            flush;

    modport master (
        output req_valid, req_addr, rsp_ready, flush,
        input  req_ready, rsp_valid, rsp_instr, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, flush,
        output req_ready, rsp_valid, rsp_instr, rsp_fault
    );

endinterface

// File: rtl/imem_array.sv
// Single-write / single-registered-read RAM, read-first on a same-address
// collision. Contents are not touched by reset.
module imem_array #(
    parameter int    XLEN      = 32,
    parameter int    DEPTH     = 32,
    parameter string INIT_FILE = "",
    localparam int   IW        = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [IW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            re,
    input  logic [IW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    // Power-up image: all-zero.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
        end
    end

    // Write port and registered read; the read samples the pre-write word.
    always @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_mem_fetch.sv
// Instruction memory with valid/ready fetch port, load port, fault reporting,
// flush and a completed-response counter. One-cycle registered read latency;
// the response register holds while the consumer stalls.
module instr_mem_fetch
    import imem_pkg::*;
#(
    parameter int    XLEN      = 32,
    parameter int    AW        = 32,
    parameter int    DEPTH     = 32,
    parameter string INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     rst,
    instr_mem_fetch_if.slave         bus,
    input  logic                     ld_we,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [XLEN-1:0]          ld_data,
    output logic [31:0]              fetch_cnt
);

    localparam int IW = $clog2(DEPTH);

    logic            accept;
    logic            complete;
    logic            misaligned;
    logic            out_of_range;
    fault_e          req_fault;
    logic            rd_en;
    logic [IW-1:0]   rd_idx;
    logic [XLEN-1:0] ram_rdata;

    logic            rsp_valid_reg;
    logic            rsp_valid_next;
    fault_e          rsp_fault_reg;
    logic            use_ram_reg;
    logic [31:0]     fetch_cnt_reg;

    // Handshake, fault classification and next response-valid state.
    always_comb begin
        bus.req_ready  = !bus.flush && (!rsp_valid_reg || bus.rsp_ready);
        accept         = bus.req_valid && bus.req_ready;
        complete       = rsp_valid_reg && bus.rsp_ready && !bus.flush;
        misaligned     = |bus.req_addr[1:0];
        out_of_range   = bus.req_addr[AW-1:2] >= (AW-2)'(DEPTH);
        req_fault      = classify_fault(misaligned, out_of_range);
        rd_en          = accept && (req_fault == FLT_NONE);
        rd_idx         = bus.req_addr[IW+1:2];
        rsp_valid_next = rsp_valid_reg;
        if (bus.flush) begin
            rsp_valid_next = 1'b0;
        end else if (accept) begin
            rsp_valid_next = 1'b1;
        end else if (complete) begin
            rsp_valid_next = 1'b0;
        end
    end

    // The RAM only reads on a fault-free accept, so its output register
    // doubles as the held instruction word during a stall.
    imem_array #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .we    (ld_we),
        .waddr (ld_addr),
        .wdata (ld_data),
        .re    (rd_en),
        .raddr (rd_idx),
        .rdata (ram_rdata)
    );

    // Response register and counter; reset drops any in-flight response at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_reg <= 1'b0;
            rsp_fault_reg <= FLT_NONE;
            use_ram_reg   <= 1'b0;
            fetch_cnt_reg <= '0;
        end else begin
            rsp_valid_reg <= rsp_valid_next;
            if (accept) begin
                rsp_fault_reg <= req_fault;
                use_ram_reg   <= (req_fault == FLT_NONE);
            end
            if (complete) begin
                fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            end
        end
    end

    // Faulted or reset responses present a NOP instead of stale RAM output.
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_fault = rsp_fault_reg;
    assign bus.rsp_instr = use_ram_reg ? ram_rdata : XLEN'(NOP_INSTR);
    assign fetch_cnt     = fetch_cnt_reg;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Self-checking bench for instr_mem_fetch: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_instr_mem_fetch;
    import imem_pkg::*;

    localparam int XLEN  = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 32;
    localparam int IW    = $clog2(DEPTH);

    logic            clk = 1'b0;
    logic            rst;
    logic            ld_we;
    logic [IW-1:0]   ld_addr;
    logic [XLEN-1:0] ld_data;
    logic [31:0]     fetch_cnt;

    instr_mem_fetch_if #(.XLEN(XLEN), .AW(AW)) bus ();

    instr_mem_fetch #(
        .XLEN      (XLEN),
        .AW        (AW),
        .DEPTH     (DEPTH),
        .INIT_FILE ("")
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_valid;
    logic [31:0] m_instr;
    logic [1:0]  m_fault;
    logic [31:0] m_cnt;
    logic [31:0] m_mem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end

    function automatic logic [1:0] exp_fault(input logic [31:0] a);
        if ((a % 4) != 0) return 2'd1;
        if ((a / 4) >= DEPTH) return 2'd2;
        return 2'd0;
    endfunction

    wire m_ready = !bus.flush && (!m_valid || bus.rsp_ready);

    // Response slot and completion counter as the rules describe them.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_instr <= NOP_INSTR;
            m_fault <= 2'd0;
            m_cnt   <= '0;
        end else begin
            if (bus.flush) begin
                m_valid <= 1'b0;
            end else if (bus.req_valid && m_ready) begin
                m_valid <= 1'b1;
                m_fault <= exp_fault(bus.req_addr);
                m_instr <= (exp_fault(bus.req_addr) == 2'd0) ? m_mem[bus.req_addr >> 2] : NOP_INSTR;
            end else if (m_valid && bus.rsp_ready) begin
                m_valid <= 1'b0;
            end
            if (m_valid && bus.rsp_ready && !bus.flush) m_cnt <= m_cnt + 32'd1;
        end
    end

    // Memory contents; a same-edge fetch above sees the old word.
    always @(posedge clk) begin
        if (ld_we) m_mem[ld_addr] <= ld_data;
    end

    // Compare process: inputs change 3 ns after this edge, outputs settled.
    always @(negedge clk) begin
        check("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
        check("fetch_cnt", fetch_cnt, m_cnt);
        check("req_ready", 32'(bus.req_ready), 32'(m_ready));
        if (m_valid) begin
            check("rsp_instr", bus.rsp_instr, m_instr);
            check("rsp_fault", 32'(bus.rsp_fault), 32'(m_fault));
        end
        if (!rst && bus.rsp_valid && bus.rsp_ready && !bus.flush)
            $display("rsp t=%0t instr=%h fault=%0d cnt=%0d", $time, bus.rsp_instr, bus.rsp_fault, fetch_cnt);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [31:0] a, input logic rr, input logic fl,
                         input logic we, input logic [IW-1:0] la, input logic [31:0] ld);
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.rsp_ready = rr;
        bus.flush     = fl;
        ld_we         = we;
        ld_addr       = la;
        ld_data       = ld;
        @(negedge clk);
        #3;
    endtask

    task automatic idle(input logic rr);
        drive(1'b0, 32'h0, rr, 1'b0, 1'b0, '0, 32'h0);
    endtask

    logic [31:0] saved_cnt;
    logic [31:0] ra;
    int          sel;

    initial begin
        rst = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b0;
        bus.flush     = 1'b0;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        #1 rst = 1'b1;
        @(negedge clk);
        #3;
        check("reset_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_instr", bus.rsp_instr, 32'h00000013);
        check("reset_fault", 32'(bus.rsp_fault), 32'd0);
        check("reset_cnt", fetch_cnt, 32'd0);
        rst = 1'b0;

        // Single fetch of a loaded word.
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd1, 32'h002081B3);
        drive(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, '0, 32'h0);
        check("t1_valid", 32'(bus.rsp_valid), 32'd1);
        check("t1_instr", bus.rsp_instr, 32'h002081B3);
        check("t1_fault", 32'(bus.rsp_fault), 32'd0);
        idle(1'b1);
        check("t1_cnt", fetch_cnt, 32'd1);

        // Back-to-back fetches.
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd2, 32'h00310233);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h00418293);
        drive(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, '0, 32'h0);
        drive(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, '0, 32'h0);
        check("t2_instr8", bus.rsp_instr, 32'h00310233);
        drive(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, '0, 32'h0);
        check("t2_instrC", bus.rsp_instr, 32'h00418293);
        idle(1'b1);
        check("t2_cnt", fetch_cnt, 32'd4);

        // Stall with a pending request, then release.
        drive(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, '0, 32'h0);
        repeat (4) begin
            drive(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, '0, 32'h0);
            check("t3_ready", 32'(bus.req_ready), 32'd0);
            check("t3_hold", bus.rsp_instr, 32'h002081B3);
        end
        drive(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, '0, 32'h0);
        check("t3_next", bus.rsp_instr, 32'h00310233);
        check("t3_cnt", fetch_cnt, 32'd5);
        idle(1'b1);

        // Faults.
        drive(1'b1, 32'h6, 1'b1, 1'b0, 1'b0, '0, 32'h0);
        check("t4_misalign", 32'(bus.rsp_fault), 32'd1);
        check("t4_mis_nop", bus.rsp_instr, 32'h00000013);
        drive(1'b1, 32'h80, 1'b1, 1'b0, 1'b0, '0, 32'h0);
        check("t4_range", 32'(bus.rsp_fault), 32'd2);
        check("t4_rng_nop", bus.rsp_instr, 32'h00000013);
        idle(1'b1);
        check("t4_cnt", fetch_cnt, 32'd8);

        // Load collides with a fetch of the same word.
        drive(1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF);
        check("t5_old", bus.rsp_instr, 32'h00418293);
        drive(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, '0, 32'h0);
        check("t5_new", bus.rsp_instr, 32'hDEADBEEF);
        idle(1'b1);
        check("t5_cnt", fetch_cnt, 32'd10);

        // Flush a held response, then reset mid-stream.
        drive(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, '0, 32'h0);
        idle(1'b0);
        saved_cnt = fetch_cnt;
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, '0, 32'h0);
        check("t6_flush_valid", 32'(bus.rsp_valid), 32'd0);
        check("t6_flush_cnt", fetch_cnt, saved_cnt);
        drive(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, '0, 32'h0);
        check("t6_pre_rst", 32'(bus.rsp_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("t6_rst_cnt", fetch_cnt, 32'd0);
        idle(1'b0);
        rst = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                rst = 1'b1;
                idle(1'b0);
                rst = 1'b0;
            end else begin
                sel = $urandom_range(0, 9);
                if (sel < 7)       ra = {25'd0, 5'($urandom_range(0, DEPTH - 1)), 2'b00};
                else if (sel == 7) ra = {25'd0, 5'($urandom), 2'($urandom_range(1, 3))};
                else if (sel == 8) ra = 32'($urandom_range(DEPTH, DEPTH + 8)) << 2;
                else               ra = $urandom;
                drive(($urandom % 4) != 0, ra, ($urandom % 10) < 7, ($urandom % 10) == 0,
                      ($urandom % 5) == 0, IW'($urandom), $urandom);
            end
        end
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
